// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned ERR_W              = 3;
    localparam int unsigned STAT_W             = 8;
    localparam int unsigned COUNT_W            = 5;

    // Bit positions inside the error tag {overrun, framing, parity}.
    localparam int unsigned ERR_PARITY  = 0;
    localparam int unsigned ERR_FRAMING = 1;
    localparam int unsigned ERR_OVERRUN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PUSH  = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [DATA_W-1:0] data;
    } rx_frame_t;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through frame FIFO; head is read straight from storage.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  rx_frame_t          wdata,
    output rx_frame_t          head_c,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rx_frame_t          mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;
    logic [COUNT_W-1:0] next_count;

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if
    // the head is leaving in the same cycle.
    always_comb begin
        do_pop     = pop & ~empty;
        do_push    = push & (~full | do_pop);
        next_count = count + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end

    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= next_count;
            full  <= (next_count == COUNT_W'(DEPTH));
            empty <= (next_count == '0);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: acknowledges UART frames, queues them with error tags,
// and keeps saturating drop/error statistics.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter bit          DROP_ON_ERR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_rdy,
    input  logic               rx_parityerr,
    input  logic               rx_framingerr,
    input  logic               rx_overrun,
    output logic               rx_read,
    input  logic               pop,
    output logic [DATA_W-1:0]  out_data,
    output logic [ERR_W-1:0]   out_err,
    output logic               out_valid,
    output logic [COUNT_W-1:0] fifo_count,
    output logic               fifo_full,
    output logic [STAT_W-1:0]  drop_cnt,
    output logic [STAT_W-1:0]  err_cnt,
    input  logic               clr_cnt
);

    rx_state_e state;
    rx_frame_t hold;
    rx_frame_t head;
    logic      fifo_empty;
    logic      in_push;
    logic      frame_err;
    logic      full_drop;
    logic      err_drop;
    logic      fifo_push;

    // rx_read is set exactly when entering PUSH, so it mirrors state==PUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rx_read <= 1'b0;
            hold    <= '0;
        end else begin
            rx_read <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_rdy) begin
                        hold.data              <= rx_data;
                        hold.err[ERR_PARITY]   <= rx_parityerr;
                        hold.err[ERR_FRAMING]  <= rx_framingerr;
                        hold.err[ERR_OVERRUN]  <= rx_overrun;
                        rx_read                <= 1'b1;
                        state                  <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!rx_rdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage decision for the held frame during its PUSH cycle.
    always_comb begin
        in_push   = (state == ST_PUSH);
        frame_err = |hold.err;
        full_drop = in_push & fifo_full & ~pop;
        err_drop  = in_push & DROP_ON_ERR & frame_err;
        fifo_push = in_push & ~full_drop & ~err_drop;
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_cnt) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (full_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (in_push && frame_err) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .pop    (pop),
        .wdata  (hold),
        .head_c (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_data  = head.data;
    assign out_err   = head.err;
    assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DROP_ON_ERR 0 and 1 instances).
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_parityerr;
    logic       rx_framingerr;
    logic       rx_overrun;
    logic       pop;
    logic       clr_cnt;

    logic       rx_read;
    logic [7:0] out_data;
    logic [2:0] out_err;
    logic       out_valid;
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;

    logic       rx_read2;
    logic [7:0] out_data2;
    logic [2:0] out_err2;
    logic       out_valid2;
    logic [4:0] fifo_count2;
    logic       fifo_full2;
    logic [7:0] drop_cnt2;
    logic [7:0] err_cnt2;

    int n_checks;
    int n_pass;
    int last_pulses;
    int total_reads;

    uart_rx_ctrl #(.FIFO_DEPTH(8), .DROP_ON_ERR(1'b0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_parityerr  (rx_parityerr),
        .rx_framingerr (rx_framingerr),
        .rx_overrun    (rx_overrun),
        .rx_read       (rx_read),
        .pop           (pop),
        .out_data      (out_data),
        .out_err       (out_err),
        .out_valid     (out_valid),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .drop_cnt      (drop_cnt),
        .err_cnt       (err_cnt),
        .clr_cnt       (clr_cnt)
    );

    uart_rx_ctrl #(.FIFO_DEPTH(8), .DROP_ON_ERR(1'b1)) dut_drop (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_parityerr  (rx_parityerr),
        .rx_framingerr (rx_framingerr),
        .rx_overrun    (rx_overrun),
        .rx_read       (rx_read2),
        .pop           (pop),
        .out_data      (out_data2),
        .out_err       (out_err2),
        .out_valid     (out_valid2),
        .fifo_count    (fifo_count2),
        .fifo_full     (fifo_full2),
        .drop_cnt      (drop_cnt2),
        .err_cnt       (err_cnt2),
        .clr_cnt       (clr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_rdy = 1'b0;
        pop = 1'b0;
        clr_cnt = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Receiver model: rx_rdy already high; drop it once acknowledged.
    // pop_p / clr_p are asserted during the PUSH cycle only.
    task automatic handshake(input logic pop_p, input logic clr_p);
        int seen;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pop = 1'b0;
            clr_cnt = 1'b0;
            if (rx_read) begin
                seen++;
                rx_rdy = 1'b0;
                pop = pop_p;
                clr_cnt = clr_p;
            end
        end
        last_pulses = seen;
        total_reads += seen;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [2:0] e,
                              input logic pop_p, input logic clr_p);
        rx_data = d;
        {rx_overrun, rx_framingerr, rx_parityerr} = e;
        rx_rdy = 1'b1;
        handshake(pop_p, clr_p);
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        total_reads = 0;
        last_pulses = 0;
        rx_data = 8'h00;
        {rx_overrun, rx_framingerr, rx_parityerr} = 3'b000;
        do_reset();

        // Reset state
        check("rst_rx_read", 32'(rx_read), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Single frame 0xA5, cycle-accurate latency
        rx_data = 8'hA5;
        rx_rdy = 1'b1;
        step();
        check("lat_read_n1", 32'(rx_read), 32'd1);
        check("lat_valid_n1", 32'(out_valid), 32'd0);
        rx_rdy = 1'b0;
        step();
        check("lat_read_n2", 32'(rx_read), 32'd0);
        check("lat_valid_n2", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_err", 32'(out_err), 32'd0);
        check("a5_count", 32'(fifo_count), 32'd1);
        step();
        step();
        check("a5_no_second_read", 32'(rx_read), 32'd0);

        // Pop to empty, then pop on empty is ignored
        pop_one();
        check("pop_empty_valid", 32'(out_valid), 32'd0);
        pop_one();
        check("underflow_count", 32'(fifo_count), 32'd0);
        check("underflow_valid", 32'(out_valid), 32'd0);

        // Nine frames, no pop: eight stored, one dropped
        do_reset();
        total_reads = 0;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(8'h10 + i), 3'b000, 1'b0, 1'b0);
        end
        check("nine_reads", 32'(total_reads), 32'd9);
        check("nine_count", 32'(fifo_count), 32'd8);
        check("nine_full", 32'(fifo_full), 32'd1);
        check("nine_drop_cnt", 32'(drop_cnt), 32'd1);
        check("nine_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("nine_order", 32'(out_data), 32'(8'h10 + i));
            pop_one();
        end
        check("nine_drained", 32'(out_valid), 32'd0);

        // Full FIFO with pop in the PUSH cycle: no drop, head advances, wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(8'h20 + i), 3'b000, 1'b0, 1'b0);
        end
        send_frame(8'h28, 3'b000, 1'b1, 1'b0);
        check("fullpop_count", 32'(fifo_count), 32'd8);
        check("fullpop_full", 32'(fifo_full), 32'd1);
        check("fullpop_drop", 32'(drop_cnt), 32'd0);
        check("fullpop_head", 32'(out_data), 32'h21);
        for (int i = 0; i < 8; i++) begin
            check("wrap_order", 32'(out_data), 32'(8'h21 + i));
            pop_one();
        end
        check("wrap_empty", 32'(fifo_count), 32'd0);

        // Push and pop together on an empty FIFO: push only
        do_reset();
        send_frame(8'h5A, 3'b000, 1'b1, 1'b0);
        check("emptypop_count", 32'(fifo_count), 32'd1);
        check("emptypop_data", 32'(out_data), 32'h5A);

        // Framing error with DROP_ON_ERR 0 (dut) and 1 (dut_drop)
        do_reset();
        send_frame(8'h3C, 3'b010, 1'b0, 1'b0);
        check("ferr_valid", 32'(out_valid), 32'd1);
        check("ferr_data", 32'(out_data), 32'h3C);
        check("ferr_tag", 32'(out_err), 32'b010);
        check("ferr_err_cnt", 32'(err_cnt), 32'd1);
        check("ferr_drop_valid", 32'(out_valid2), 32'd0);
        check("ferr_drop_count", 32'(fifo_count2), 32'd0);
        check("ferr_drop_err_cnt", 32'(err_cnt2), 32'd1);
        check("ferr_drop_drop_cnt", 32'(drop_cnt2), 32'd0);
        send_frame(8'h77, 3'b000, 1'b0, 1'b0);
        check("ferr_drop_clean_data", 32'(out_data2), 32'h77);
        check("ferr_drop_clean_tag", 32'(out_err2), 32'd0);
        check("ferr_drop_clean_full", 32'(fifo_full2), 32'd0);
        check("ferr_drop_read_idle", 32'(rx_read2), 32'd0);

        // Counter saturation, then clear coincident with another error
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame(8'(i), 3'b001, 1'b0, 1'b0);
        end
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        send_frame(8'hEE, 3'b100, 1'b0, 1'b1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        send_frame(8'hEF, 3'b100, 1'b0, 1'b0);
        check("post_clr_err_cnt", 32'(err_cnt), 32'd1);
        check("post_clr_drop_cnt", 32'(drop_cnt), 32'd1);

        // Reset while in DRAIN with rx_rdy still high
        do_reset();
        rx_data = 8'h55;
        {rx_overrun, rx_framingerr, rx_parityerr} = 3'b000;
        rx_rdy = 1'b1;
        step();
        check("mid_read", 32'(rx_read), 32'd1);
        step();
        step();
        check("mid_stored", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_read", 32'(rx_read), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        handshake(1'b0, 1'b0);
        check("mid_new_reads", 32'(last_pulses), 32'd1);
        check("mid_new_count", 32'(fifo_count), 32'd1);
        check("mid_new_data", 32'(out_data), 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of FIFO entries (power of two, 2..16).
REQ-002 Parameter DROP_ON_ERR, default 0; when 1, frames with any error flag are not stored.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received byte from UART receiver.
REQ-006 rx_rdy  in  1  receiver ready flag; held high until acknowledged.
REQ-007 rx_parityerr, rx_framingerr, rx_overrun  in  1 each  receiver error flags, valid while rx_rdy high.
REQ-008 rx_read  out  1  one-cycle acknowledge to receiver (clears its ready flag).
REQ-009 pop  in  1  host consumes FIFO head.
REQ-010 out_data  out  8  FIFO head byte, valid when out_valid high.
REQ-011 out_err  out  3  head error tag {overrun, framing, parity}.
REQ-012 out_valid  out  1  FIFO not empty.
REQ-013 fifo_count  out  5  current occupancy, 0..FIFO_DEPTH.
REQ-014 fifo_full  out  1  occupancy equals FIFO_DEPTH.
REQ-015 drop_cnt, err_cnt  out  8 each  saturating counters of dropped frames and errored frames.
REQ-016 clr_cnt  in  1  synchronous clear of drop_cnt and err_cnt.

Function
REQ-017 FSM states IDLE, PUSH, DRAIN; state held in a registered state variable.
REQ-018 IDLE: rx_rdy high -> latch rx_data and the three flags into a holding register, go to PUSH.
REQ-019 PUSH: rx_read high for exactly this one cycle; write holding register to FIFO unless dropped; go to DRAIN.
REQ-020 DRAIN: stay while rx_rdy high; rx_rdy low -> IDLE; rx_read low.
REQ-021 rx_read is decoded only from state==PUSH; never high two consecutive cycles.
REQ-022 Latency: rx_rdy sampled high at edge N -> rx_read high cycle N+1 -> out_valid high from N+2 when FIFO was empty.
REQ-023 Frame dropped when FIFO full and pop low in PUSH, or DROP_ON_ERR=1 and any flag set; full-drop increments drop_cnt.
REQ-024 Any flag set in latched frame increments err_cnt, regardless of storage.
REQ-025 FIFO is first-word-fall-through; out_data/out_err show head combinationally from storage.
REQ-026 pop with out_valid low is ignored; no underflow, count unchanged.
REQ-027 Push and pop same cycle when full: both performed, count unchanged, no drop.
REQ-028 Push and pop same cycle when empty: push only; pop ignored.
REQ-029 Read/write pointers wrap modulo FIFO_DEPTH.
REQ-030 Counters saturate at 255; clr_cnt has priority over a simultaneous increment (result 0).

Reset
REQ-031 rst: state IDLE, rx_read 0, FIFO empty (pointers 0, fifo_count 0, out_valid 0, fifo_full 0), drop_cnt 0, err_cnt 0, holding register 0.
REQ-032 rst mid-frame (PUSH or DRAIN) discards the frame; a still-high rx_rdy after reset is treated as a new frame.

Structure
REQ-033 Shared package uart_pkg holds the FSM state enum, error-tag bit index constants, and FIFO_DEPTH default.
REQ-034 FIFO implemented as sub-module uart_rx_fifo (11-bit entries, FWFT, count/full/empty outputs).

Verification
REQ-035 Single frame 0xA5 no errors, rx_rdy held until rx_read -> one rx_read pulse, out_data 0xA5, out_err 000, fifo_count 1.
REQ-036 Nine frames with no pop, FIFO_DEPTH 8 -> fifo_count 8, fifo_full 1, drop_cnt 1, nine rx_read pulses.
REQ-037 Frame 0x3C with framing error, DROP_ON_ERR 0 -> stored with out_err 010, err_cnt 1; DROP_ON_ERR 1 -> not stored, err_cnt 1.
REQ-038 FIFO full, frame arrives with pop high in PUSH cycle -> no drop, count stays 8, head advances.
REQ-039 300 errored frames then clr_cnt coincident with another error -> err_cnt saturates 255, then 0.
REQ-040 rst asserted in DRAIN with rx_rdy high -> all outputs reset values; after release one new rx_read pulse.
